// File: rtl/vector_bundle_fifo.sv
// vector_bundle_fifo
//   Circular FIFO of DEPTH bundles, each made of three independently ranged
//   vector fields. Ranges may start at a non-zero LSB and are carried to the
//   outputs unchanged (out_vectorN[k] mirrors vectorN[k]).
//   MODE 0 applies backpressure when full; MODE 1 always accepts and, when
//   full without a simultaneous pop, overwrites the oldest entry and pulses
//   drop for one cycle.
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   in_valid/in_ready            producer handshake
//   vector0..2                   bundle fields in
//   out_valid/out_ready          consumer handshake
//   out_vector0..2               head bundle fields, zero when empty
//   count                        number of stored bundles
//   drop                         one-cycle overwrite indication (MODE 1)
module vector_bundle_fifo #(
  parameter int V0_MSB = 1,
  parameter int V0_LSB = 1,
  parameter int V1_MSB = 8,
  parameter int V1_LSB = 1,
  parameter int V2_MSB = 20,
  parameter int V2_LSB = 5,
  parameter int DEPTH  = 4,
  parameter int MODE   = 0,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [V0_MSB:V0_LSB] vector0,
  input  logic [V1_MSB:V1_LSB] vector1,
  input  logic [V2_MSB:V2_LSB] vector2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [V0_MSB:V0_LSB] out_vector0,
  output logic [V1_MSB:V1_LSB] out_vector1,
  output logic [V2_MSB:V2_LSB] out_vector2,
  output logic [CW-1:0]        count,
  output logic                 drop
);

  localparam int W0 = V0_MSB - V0_LSB + 1;
  localparam int W1 = V1_MSB - V1_LSB + 1;
  localparam int W2 = V2_MSB - V2_LSB + 1;
  localparam int BW = W0 + W1 + W2;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [BW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          drop_r;

  logic          full_s;
  logic          empty_s;
  logic          in_ready_s;
  logic          push_s;
  logic          pop_s;
  logic          overwrite_s;
  logic [BW-1:0] head_s;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      next_ptr = {PW{1'b0}};
    end else begin
      next_ptr = p + PW'(1);
    end
  endfunction

  // Handshake decode and head selection, all derived from registered state.
  always_comb begin
    full_s  = (count_r == FULL_CNT);
    empty_s = (count_r == {CW{1'b0}});
    if (rst) begin
      in_ready_s = 1'b0;
    end else if (MODE == 1) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = ~full_s;
    end
    push_s      = in_valid & in_ready_s;
    pop_s       = ~empty_s & out_ready & ~rst;
    // Only reachable in MODE 1, since MODE 0 never accepts while full.
    overwrite_s = push_s & ~pop_s & full_s;
    if (empty_s) begin
      head_s = {BW{1'b0}};
    end else begin
      head_s = mem_r[rd_ptr_r];
    end
  end

  // Bundle storage; contents are don't-care after reset so no reset branch.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {vector0, vector1, vector2};
    end
  end

  // Pointers, occupancy and the overwrite pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      drop_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      // An overwrite consumes the oldest slot, so the read side moves too.
      if (pop_s | overwrite_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      if (push_s & ~pop_s & ~full_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_s & ~push_s) begin
        count_r <= count_r - CW'(1);
      end
      drop_r <= overwrite_s;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = ~empty_s;
  assign out_vector0 = head_s[BW-1 -: W0];
  assign out_vector1 = head_s[W1+W2-1 -: W1];
  assign out_vector2 = head_s[W2-1:0];
  assign count       = count_r;
  assign drop        = drop_r;

endmodule

// File: doc/vector_bundle_fifo.md
VECTOR_BUNDLE_FIFO -- requirements
Module: vector_bundle_fifo

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  V0_MSB, 1, vector0 upper bound
  V0_LSB, 1, vector0 lower bound
  V1_MSB, 8, vector1 upper bound
  V1_LSB, 1, vector1 lower bound
  V2_MSB, 20, vector2 upper bound
  V2_LSB, 5, vector2 lower bound
  DEPTH, 4, bundle entries (≥2, any integer)
  MODE, 0, 0 = backpressure when full, 1 = overwrite oldest when full
REQ-002 CW SHALL be derived as ceil(log2(DEPTH+1)), and each MSB SHALL be ≥ its LSB; LSB may be non-zero.
REQ-003 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  synchronous, active-high reset
  in_valid  in  1  producer offers bundle
  in_ready  out  1  block accepts bundle
  vector0  in  [V0_MSB:V0_LSB]  field 0
  vector1  in  [V1_MSB:V1_LSB]  field 1
  vector2  in  [V2_MSB:V2_LSB]  field 2
  out_valid  out  1  head bundle available
  out_ready  in  1  consumer takes head
  out_vector0  out  [V0_MSB:V0_LSB]  head field 0
  out_vector1  out  [V1_MSB:V1_LSB]  head field 1
  out_vector2  out  [V2_MSB:V2_LSB]  head field 2
  count  out  [CW-1:0]  stored entries
  drop  out  1  one-cycle pulse, oldest entry overwritten (MODE 1 only)
REQ-004 Output ports SHALL carry exactly the declared ranges of the corresponding inputs; out_vectorN[k] SHALL equal the vectorN[k] captured, for every k in range (no re-basing to bit 0).

Function
REQ-005 Push SHALL occur on a rising edge with in_valid & in_ready; pop SHALL occur on a rising edge with out_valid & out_ready.
REQ-006 Storage SHALL be a circular buffer of DEPTH bundles; write and read pointers SHALL wrap from DEPTH-1 to 0, including non-power-of-two DEPTH.
REQ-007 A pushed bundle SHALL become visible at the output one cycle after the push edge; there SHALL be no combinational in-to-out path.
REQ-008 out_valid SHALL be 1 iff count ≠ 0; out_vector* SHALL show the oldest entry when out_valid=1 and SHALL be all-zero when out_valid=0.
REQ-009 MODE 0: in_ready SHALL be 1 iff count < DEPTH and rst=0; no data SHALL ever be lost.
REQ-010 MODE 1: in_ready SHALL be 1 whenever rst=0; push at count=DEPTH without pop SHALL overwrite the oldest entry, advance the read pointer, keep count=DEPTH and assert drop for exactly the next cycle.
REQ-011 Simultaneous push and pop SHALL leave count unchanged, in both modes and at count=DEPTH in MODE 1, with drop=0.
REQ-012 Pop at count=0 SHALL be impossible (out_valid=0); push with in_ready=0 SHALL be ignored.
REQ-013 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or underflow 0.
REQ-014 Handshake stability: while out_valid=1 and out_ready=0, out_vector* SHALL be stable unless a MODE 1 overwrite occurs (signalled by drop).

Reset
REQ-015 On a rising edge with rst=1: pointers, count and drop SHALL clear to 0, and out_valid SHALL be 0 in the following cycle; storage contents need not reset.
REQ-016 While rst=1, in_ready SHALL be 0, and push/pop attempts SHALL be ignored; reset mid-operation SHALL discard all stored entries.
REQ-017 After rst falls, the first push SHALL be accepted on the first edge with rst=0.

Verification
REQ-018 Defaults, push {1'b1, 8'hA5, 16'h1234} with out_ready=0 -> next cycle out_valid=1, out_vector1[8:1]=8'hA5, out_vector2[20:5]=16'h1234, count=1.
REQ-019 MODE 0, DEPTH 4, 5 pushes with out_ready=0 -> in_ready=0 after the 4th, count=4, 5th ignored; 4 pops return pushes 1..4 in order.
REQ-020 MODE 1, DEPTH 4, pushes 1..5 with out_ready=0 -> drop=1 for one cycle after the 5th, count=4, head=bundle 2.
REQ-021 DEPTH 3, 10 pushes interleaved with pops (pointer wrap) -> output order identical to input order, count ≤3 throughout.
REQ-022 count=2, rst=1 for one cycle concurrent with push and pop -> count=0, out_valid=0, out_vector*=0 next cycle; subsequent push accepted.
REQ-023 count=4 full, MODE 1, push and pop same edge -> count=4, drop=0, head advances by one.
